// File: rtl/nco_freq_sequencer.sv
// nco_freq_sequencer
//   Sits between the UART receiver and the sine-wave NCO. It decodes ASCII
//   command bytes into a target phase increment (presets, saturating coarse
//   and fine steps, mute, optional sweep). It commits that target to the NCO
//   only on a DAC sample tick, so no sample uses a half-updated increment.
//
//   Optional feature: define NCO_SWEEP_EN to build the 's' sweep command,
//   the SWEEP state, the dwell counter and a live 'sweeping' output. Without
//   the macro, 's' counts as an unrecognised byte and 'sweeping' stays 0.
//
// Ports
//   clk              system clock
//   rst              synchronous reset, active high
//   cmd_valid        1-cycle strobe, cmd_byte is valid
//   cmd_byte         ASCII command byte
//   sample_tick      1-cycle strobe once per DAC sample
//   phase_increment  committed increment driving the NCO
//   inc_update       1-cycle pulse when phase_increment changes value
//   sweeping         high while in the SWEEP state
//   cmd_err_cnt      count of unrecognised bytes, saturates at 255
//
// Commands
//   'a' 'b' 'f' 'g'  load 1x / 5x / 10x / 15x the coarse step
//   'm' 'n'          add / subtract the coarse step (saturating)
//   'p' 'o'          add / subtract the fine step (saturating)
//   'x'              mute (target 0)
//   's'              start or restart a sweep (NCO_SWEEP_EN builds only)
//
// State table (NCO_SWEEP_EN builds)
//   state   | meaning
//   S_IDLE  | target changes only on commands
//   S_SWEEP | target advances by one coarse step every SWEEP_DWELL ticks

module nco_freq_sequencer #(
    parameter int                     PHASE_WIDTH = 64,
    parameter logic [PHASE_WIDTH-1:0] STEP_COARSE = 64'd196765270119568550,
    parameter logic [PHASE_WIDTH-1:0] STEP_FINE   = 64'd19676527011956855,
    parameter logic [PHASE_WIDTH-1:0] INC_MAX     = 64'h7FFF_FFFF_FFFF_FFFF,
    parameter int                     SWEEP_DWELL = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    input  logic [7:0]             cmd_byte,
    input  logic                   sample_tick,
    output logic [PHASE_WIDTH-1:0] phase_increment,
    output logic                   inc_update,
    output logic                   sweeping,
    output logic [7:0]             cmd_err_cnt
);

    // Presets built from shifts and adds, so they truncate to PHASE_WIDTH.
    localparam logic [PHASE_WIDTH-1:0] PRESET_5  = (STEP_COARSE << 2) + STEP_COARSE;
    localparam logic [PHASE_WIDTH-1:0] PRESET_10 = (STEP_COARSE << 3) + (STEP_COARSE << 1);
    localparam logic [PHASE_WIDTH-1:0] PRESET_15 = (STEP_COARSE << 4) - STEP_COARSE;

    logic [PHASE_WIDTH-1:0] target;
    logic                   pend;

    // Sums carry one extra bit, so an overflow past INC_MAX is visible
    // instead of wrapping.
    logic [PHASE_WIDTH:0]   add_c;
    logic [PHASE_WIDTH:0]   add_f;
    logic                   ovf_c;
    logic                   ovf_f;
    logic [PHASE_WIDTH-1:0] cmd_result;
    logic                   cmd_known;

    assign add_c = {1'b0, target} + {1'b0, STEP_COARSE};
    assign add_f = {1'b0, target} + {1'b0, STEP_FINE};
    assign ovf_c = add_c > {1'b0, INC_MAX};
    assign ovf_f = add_f > {1'b0, INC_MAX};

`ifdef NCO_SWEEP_EN
    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    localparam logic [15:0] DWELL_LAST = 16'(SWEEP_DWELL - 1);

    state_t                 state;
    logic [PHASE_WIDTH-1:0] sweep_base;
    logic [15:0]            dwell_cnt;
    logic                   cmd_sweep;
    logic [PHASE_WIDTH-1:0] sweep_next;

    assign cmd_sweep  = (cmd_byte == 8'h73);
    // A sweep wraps back to its starting value instead of saturating.
    assign sweep_next = ovf_c ? sweep_base : add_c[PHASE_WIDTH-1:0];
`else
    assign sweeping = 1'b0;
`endif

    always_comb begin
        cmd_known  = 1'b1;
        cmd_result = target;
        case (cmd_byte)
            8'h61:   cmd_result = STEP_COARSE;                                    // 'a'
            8'h62:   cmd_result = PRESET_5;                                       // 'b'
            8'h66:   cmd_result = PRESET_10;                                      // 'f'
            8'h67:   cmd_result = PRESET_15;                                      // 'g'
            8'h6D:   cmd_result = ovf_c ? INC_MAX : add_c[PHASE_WIDTH-1:0];       // 'm'
            8'h6E:   cmd_result = (target < STEP_COARSE) ? '0 : target - STEP_COARSE; // 'n'
            8'h70:   cmd_result = ovf_f ? INC_MAX : add_f[PHASE_WIDTH-1:0];       // 'p'
            8'h6F:   cmd_result = (target < STEP_FINE) ? '0 : target - STEP_FINE; // 'o'
            8'h78:   cmd_result = '0;                                             // 'x'
            default: cmd_known  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_increment <= '0;
            target          <= '0;
            pend            <= 1'b0;
            inc_update      <= 1'b0;
            cmd_err_cnt     <= '0;
`ifdef NCO_SWEEP_EN
            state           <= S_IDLE;
            sweeping        <= 1'b0;
            sweep_base      <= '0;
            dwell_cnt       <= '0;
`endif
        end else begin
            inc_update <= 1'b0;

            // Commit uses the target as it stood before this cycle's command.
            if (sample_tick && pend) begin
                phase_increment <= target;
                inc_update      <= (target != phase_increment);
                pend            <= 1'b0;
            end

`ifdef NCO_SWEEP_EN
            if (state == S_SWEEP && sample_tick) begin
                if (dwell_cnt == DWELL_LAST) begin
                    dwell_cnt <= '0;
                    target    <= sweep_next;
                    pend      <= 1'b1;
                end else begin
                    dwell_cnt <= dwell_cnt + 16'd1;
                end
            end
`endif

            // Commands come last so they win over a sweep step in the same cycle.
            if (cmd_valid) begin
`ifdef NCO_SWEEP_EN
                if (cmd_sweep) begin
                    state      <= S_SWEEP;
                    sweeping   <= 1'b1;
                    sweep_base <= target;
                    dwell_cnt  <= '0;
                end else
`endif
                if (cmd_known) begin
                    target <= cmd_result;
                    pend   <= 1'b1;
`ifdef NCO_SWEEP_EN
                    state    <= S_IDLE;
                    sweeping <= 1'b0;
`endif
                end else if (cmd_err_cnt != 8'hFF) begin
                    cmd_err_cnt <= cmd_err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nco_freq_sequencer.sv
module tb_nco_freq_sequencer;

    localparam logic [63:0] S       = 64'd196765270119568550;
    localparam logic [63:0] F       = 64'd19676527011956855;
    localparam logic [63:0] INC_MAX = 64'h7FFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        sample_tick;
    logic [63:0] phase_increment;
    logic        inc_update;
    logic        sweeping;
    logic [7:0]  cmd_err_cnt;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int exp_err   = 0;

    nco_freq_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_byte        (cmd_byte),
        .sample_tick     (sample_tick),
        .phase_increment (phase_increment),
        .inc_update      (inc_update),
        .sweeping        (sweeping),
        .cmd_err_cnt     (cmd_err_cnt)
    );

    always #5 clk = ~clk;

    // All drives and samples happen on the falling edge.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] c);
        cmd_valid = 1'b1;
        cmd_byte  = c;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_byte = 8'h00; sample_tick = 1'b0;
        idle(3);
        check_cnt++;
        if (phase_increment !== 64'd0 || inc_update !== 1'b0 || sweeping !== 1'b0 || cmd_err_cnt !== 8'd0)
            $display("FAIL reset: inc=%0d upd=%b swp=%b err=%0d want all 0",
                     phase_increment, inc_update, sweeping, cmd_err_cnt);
        else pass_cnt++;
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_preset();
        send(8'h61);
        idle(2);
        check_cnt++;
        if (phase_increment !== 64'd0)
            $display("FAIL preset_before_tick: got %0d want 0", phase_increment);
        else pass_cnt++;
        tick(1);
        check_cnt++;
        if (phase_increment !== S || inc_update !== 1'b1)
            $display("FAIL preset_a: got %0d upd=%b want %0d upd=1", phase_increment, inc_update, S);
        else pass_cnt++;
        idle(1);
        check_cnt++;
        if (inc_update !== 1'b0)
            $display("FAIL preset_pulse_width: upd=%b want 0", inc_update);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        send(8'h67);
        for (int i = 0; i < 40; i++) send(8'h6D);
        tick(1);
        check_cnt++;
        if (phase_increment !== INC_MAX || inc_update !== 1'b1)
            $display("FAIL saturate_max: got %0h upd=%b want %0h", phase_increment, inc_update, INC_MAX);
        else pass_cnt++;
        send(8'h6E);
        tick(1);
        check_cnt++;
        if (phase_increment !== 64'd9026606766735207257)
            $display("FAIL saturate_minus: got %0d want 9026606766735207257", phase_increment);
        else pass_cnt++;
    endtask

    task automatic test_floor_and_error();
        send(8'h78);
        tick(1);
        check_cnt++;
        if (phase_increment !== 64'd0 || inc_update !== 1'b1)
            $display("FAIL mute: got %0d upd=%b want 0 upd=1", phase_increment, inc_update);
        else pass_cnt++;
        send(8'h6F);
        tick(1);
        check_cnt++;
        if (phase_increment !== 64'd0 || inc_update !== 1'b0)
            $display("FAIL floor_o: got %0d upd=%b want 0 upd=0", phase_increment, inc_update);
        else pass_cnt++;
        send(8'h7A);
        exp_err++;
        check_cnt++;
        if (cmd_err_cnt !== 8'(exp_err) || phase_increment !== 64'd0)
            $display("FAIL bad_byte: err=%0d inc=%0d want err=%0d inc=0", cmd_err_cnt, phase_increment, exp_err);
        else pass_cnt++;
        tick(1);
        check_cnt++;
        if (inc_update !== 1'b0 || phase_increment !== 64'd0)
            $display("FAIL bad_byte_tick: upd=%b inc=%0d want upd=0 inc=0", inc_update, phase_increment);
        else pass_cnt++;
    endtask

    task automatic test_fine();
        send(8'h70);
        send(8'h70);
        tick(1);
        check_cnt++;
        if (phase_increment !== 64'd39353054023913710)
            $display("FAIL fine_up: got %0d want 39353054023913710", phase_increment);
        else pass_cnt++;
        send(8'h6F);
        tick(1);
        check_cnt++;
        if (phase_increment !== F)
            $display("FAIL fine_down: got %0d want %0d", phase_increment, F);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        send(8'h61);
        cmd_valid = 1'b1; cmd_byte = 8'h62; sample_tick = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; sample_tick = 1'b0;
        check_cnt++;
        if (phase_increment !== S || inc_update !== 1'b1)
            $display("FAIL collide_old: got %0d upd=%b want %0d", phase_increment, inc_update, S);
        else pass_cnt++;
        tick(1);
        check_cnt++;
        if (phase_increment !== 64'd983826350597842750)
            $display("FAIL collide_new: got %0d want 983826350597842750", phase_increment);
        else pass_cnt++;
        send(8'h66);
        tick(1);
        check_cnt++;
        if (phase_increment !== 64'd1967652701195685500)
            $display("FAIL preset_f: got %0d want 1967652701195685500", phase_increment);
        else pass_cnt++;
    endtask

`ifdef NCO_SWEEP_EN
    task automatic test_sweep();
        send(8'h61);
        tick(1);
        send(8'h73);
        check_cnt++;
        if (sweeping !== 1'b1)
            $display("FAIL sweep_enter: swp=%b want 1", sweeping);
        else pass_cnt++;
        tick(48);
        check_cnt++;
        if (phase_increment !== S)
            $display("FAIL sweep_dwell: got %0d want %0d", phase_increment, S);
        else pass_cnt++;
        tick(1);
        check_cnt++;
        if (phase_increment !== 64'd393530540239137100 || inc_update !== 1'b1)
            $display("FAIL sweep_k1: got %0d upd=%b want 393530540239137100", phase_increment, inc_update);
        else pass_cnt++;
        tick(48);
        check_cnt++;
        if (phase_increment !== 64'd590295810358705650)
            $display("FAIL sweep_k2: got %0d want 590295810358705650", phase_increment);
        else pass_cnt++;
        tick(48 * 43);
        check_cnt++;
        if (phase_increment !== 64'd9051202425500153300)
            $display("FAIL sweep_top: got %0d want 9051202425500153300", phase_increment);
        else pass_cnt++;
        tick(48);
        check_cnt++;
        if (phase_increment !== S || inc_update !== 1'b1)
            $display("FAIL sweep_wrap: got %0d upd=%b want %0d", phase_increment, inc_update, S);
        else pass_cnt++;
        send(8'h78);
        check_cnt++;
        if (sweeping !== 1'b0)
            $display("FAIL sweep_exit: swp=%b want 0", sweeping);
        else pass_cnt++;
        tick(1);
        check_cnt++;
        if (phase_increment !== 64'd0)
            $display("FAIL sweep_mute: got %0d want 0", phase_increment);
        else pass_cnt++;
    endtask
`else
    task automatic test_sweep();
        send(8'h73);
        exp_err++;
        check_cnt++;
        if (cmd_err_cnt !== 8'(exp_err) || sweeping !== 1'b0)
            $display("FAIL no_sweep_s: err=%0d swp=%b want err=%0d swp=0", cmd_err_cnt, sweeping, exp_err);
        else pass_cnt++;
        tick(1);
        check_cnt++;
        if (inc_update !== 1'b0 || phase_increment !== 64'd1967652701195685500)
            $display("FAIL no_sweep_tick: got %0d upd=%b want 1967652701195685500 upd=0",
                     phase_increment, inc_update);
        else pass_cnt++;
    endtask
`endif

    task automatic test_err_saturate();
        for (int i = 0; i < 260; i++) send(8'h7A);
        check_cnt++;
        if (cmd_err_cnt !== 8'd255)
            $display("FAIL err_saturate: got %0d want 255", cmd_err_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_pending();
        send(8'h67);
`ifdef NCO_SWEEP_EN
        send(8'h73);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_cnt++;
        if (phase_increment !== 64'd0 || inc_update !== 1'b0 || sweeping !== 1'b0 || cmd_err_cnt !== 8'd0)
            $display("FAIL reset_pend: inc=%0d upd=%b swp=%b err=%0d want all 0",
                     phase_increment, inc_update, sweeping, cmd_err_cnt);
        else pass_cnt++;
        tick(60);
        check_cnt++;
        if (phase_increment !== 64'd0 || inc_update !== 1'b0 || sweeping !== 1'b0)
            $display("FAIL reset_no_commit: inc=%0d upd=%b swp=%b want 0", phase_increment, inc_update, sweeping);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_preset();
        test_saturate();
        test_floor_and_error();
        test_fine();
        test_back_to_back();
        test_sweep();
        test_err_saturate();
        test_reset_pending();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
